btn_cond: RTL and testbench
===========================

BTN_COND -- requirements
Module: btn_cond

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 250000, meaning the number of consecutive stable clk cycles required to accept a debounced level change (5 ms at 50 MHz).
REQ-002 The block SHALL have parameter CNT_W, default 18, meaning the debounce counter width; it SHALL satisfy 2**CNT_W > DB_CYCLES.
REQ-003 The block SHALL have port clk, input, 1, the system clock.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port btn_raw, input, 3, asynchronous mechanical button levels, where 1 means pressed.
REQ-006 The block SHALL have port btn_out, output, 3, a one-cycle one-hot press pulse (001, 010 or 100), or 000 otherwise.
REQ-007 The block SHALL have port btn_level, output, 3, the debounced button levels.
REQ-008 The block SHALL have port conflict, output, 1, a one-cycle pulse when two or more buttons are accepted in the same cycle.
REQ-009 The block SHALL have port press_cnt, output, 8, the count of emitted btn_out pulses, wrapping modulo 256.

Function
REQ-010 Each btn_raw bit SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-011 Each channel SHALL have a counter that clears whenever the synchronized value equals btn_level[i], and otherwise increments.
REQ-012 When a channel's counter equals DB_CYCLES-1 and the synchronized value still differs from btn_level[i], btn_level[i] SHALL toggle on the next edge and the counter SHALL clear.
REQ-013 A clean step on btn_raw[i] SHALL therefore appear on btn_level[i] exactly DB_CYCLES+2 clk edges later.
REQ-014 A glitch on any channel shorter than DB_CYCLES synchronized cycles SHALL NOT change btn_level on that channel.
REQ-015 A rising edge of btn_level[i] SHALL be detected by comparing btn_level against its value registered one cycle earlier.
REQ-016 The FSM SHALL have two states: IDLE and HELD.
REQ-017 In IDLE, if exactly one btn_level bit rises, btn_out SHALL equal that one-hot value for the following cycle only, press_cnt SHALL increment, and the FSM SHALL enter HELD.
REQ-018 In IDLE, if two or more btn_level bits rise in the same cycle, conflict SHALL pulse for one cycle, btn_out SHALL stay 000, press_cnt SHALL be unchanged, and the FSM SHALL enter HELD.
REQ-019 In HELD, btn_out SHALL be 000 and further rises SHALL be ignored.
REQ-020 In HELD, when btn_level == 000, the FSM SHALL return to IDLE on the next edge.
REQ-021 btn_out SHALL never carry a non-one-hot non-zero value, so that the downstream selector never sees its invalid-code case.
REQ-022 press_cnt SHALL wrap from 255 to 0 without any other effect.
REQ-023 A channel rising while any other channel is already held SHALL be ignored until all buttons are released.

Reset
REQ-024 When rst = 0, all of the following SHALL clear asynchronously: synchronizers, counters, btn_level, the edge register, btn_out, conflict and press_cnt, with the FSM in IDLE.
REQ-025 Reset SHALL be released synchronously through the flop chain; no pulse SHALL be emitted for a button already held at reset release until it has debounced (DB_CYCLES+2 edges).
REQ-026 An assertion of rst mid-debounce or in HELD SHALL abort the operation with no pulse emitted.

Structure
REQ-027 Package btn_cond_pkg SHALL hold: the FSM state type {IDLE, HELD}, the DB_CYCLES default, and the button index constants BTN0=0, BTN1=1, BTN2=2.
REQ-028 Sub-module btn_debounce SHALL contain one channel's synchronizer, counter and level; btn_cond SHALL instantiate it three times.
REQ-029 The edge detection, FSM and press_cnt SHALL reside in btn_cond.

Verification (bench uses DB_CYCLES=4, CNT_W=3)
REQ-030 Hold btn_raw=001 steady from edge 0 -> btn_level=001 at edge 6, btn_out=001 for exactly one cycle at edge 7, press_cnt=1.
REQ-031 Pulse btn_raw[1] high for 3 cycles -> btn_level, btn_out and press_cnt unchanged.
REQ-032 Step btn_raw from 000 to 101 on one edge -> conflict pulses once, btn_out stays 000, press_cnt unchanged; then release to 000 and press 010 -> btn_out=010 once.
REQ-033 Hold 001, then add 100 while 001 is held -> only the 001 pulse occurs; release all, then press 100 -> btn_out=100 once.
REQ-034 Perform 256 clean press/release cycles on btn_raw[0] -> press_cnt returns to 0.
REQ-035 Assert rst mid-debounce with btn_raw=010 held, then release rst -> no pulse until 6 edges after release, then exactly one 010 pulse.

Source files
------------

// File: rtl/btn_cond_pkg.sv
// Shared types and constants for the three-button conditioner.
// Holds the press FSM state type, default debounce length and button indices.
package btn_cond_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  localparam int DB_CYCLES_DEFAULT = 250000;
  localparam int NUM_BTN           = 3;

  localparam int BTN0 = 0;
  localparam int BTN1 = 1;
  localparam int BTN2 = 2;

  // True when exactly one bit is set.
  function automatic logic is_onehot(input logic [NUM_BTN-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, stability counter and debounced level.
// The level toggles only after DB_CYCLES consecutive synchronized samples differ from it.
module btn_debounce
  import btn_cond_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int CNT_W     = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  logic             sync1_reg;
  logic             sync2_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             level_reg;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      // Any sample agreeing with the current level restarts the stability window.
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        cnt_reg   <= '0;
        level_reg <= ~level_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign level = level_reg;

endmodule

// File: rtl/btn_cond.sv
// Three-button conditioner: debounced levels, one-hot press pulse, conflict flag
// and a wrapping press counter. One press is accepted per full release of all buttons.
module btn_cond
  import btn_cond_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int CNT_W     = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn_raw,
  output logic [2:0] btn_out,
  output logic [2:0] btn_level,
  output logic       conflict,
  output logic [7:0] press_cnt
);

  state_t     state_reg, state_next;
  logic [2:0] level_d_reg;
  logic [2:0] out_reg, out_next;
  logic       conflict_reg, conflict_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [2:0] rise;

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
      btn_debounce #(
        .DB_CYCLES(DB_CYCLES),
        .CNT_W    (CNT_W)
      ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .raw  (btn_raw[gi]),
        .level(btn_level[gi])
      );
    end
  endgenerate

  assign rise = btn_level & ~level_d_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      level_d_reg  <= '0;
      out_reg      <= '0;
      conflict_reg <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      level_d_reg  <= btn_level;
      out_reg      <= out_next;
      conflict_reg <= conflict_next;
      cnt_reg      <= cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    out_next      = '0;
    conflict_next = 1'b0;
    cnt_next      = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (rise != '0) begin
          state_next = HELD;
          // Simultaneous rises are ambiguous, so only flag them; never emit a multi-hot code.
          if (is_onehot(rise)) begin
            out_next = rise;
            cnt_next = cnt_reg + 8'd1;
          end else begin
            conflict_next = 1'b1;
          end
        end
      end
      HELD: begin
        if (btn_level == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign btn_out   = out_reg;
  assign conflict  = conflict_reg;
  assign press_cnt = cnt_reg;

endmodule

// File: tb/tb_btn_cond.sv
// Randomized bench for btn_cond against a cycle-level behavioural model,
// plus directed scenarios for the documented press/conflict/reset cases.
module tb_btn_cond;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] btn_raw = 3'b000;
  logic [2:0] btn_out;
  logic [2:0] btn_level;
  logic       conflict;
  logic [7:0] press_cnt;

  int checks = 0;
  int errors = 0;

  btn_cond #(.DB_CYCLES(DB), .CNT_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .btn_out  (btn_out),
    .btn_level(btn_level),
    .conflict (conflict),
    .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: raw samples reach the filter two edges late; a level flips after
  // DB consecutive disagreeing samples; one press is accepted per full release.
  logic [2:0] raw_q[$];
  int         run[3];
  logic [2:0] m_level, m_level_d, e_out;
  logic       e_conf, armed;
  logic [7:0] e_cnt;

  task automatic model_reset();
    raw_q.delete();
    for (int i = 0; i < 3; i++) run[i] = 0;
    m_level = 0; m_level_d = 0; e_out = 0; e_conf = 0; armed = 1; e_cnt = 0;
  endtask

  task automatic model_step(input logic [2:0] raw_now);
    logic [2:0] seen, rise;
    seen = (raw_q.size() == 2) ? raw_q.pop_front() : 3'b000;
    raw_q.push_back(raw_now);
    rise = m_level & ~m_level_d;
    e_out = 0; e_conf = 0;
    if (armed && rise != 0) begin
      armed = 0;
      if ($countones(rise) == 1) begin e_out = rise; e_cnt = e_cnt + 8'd1; end
      else e_conf = 1;
    end else if (!armed && m_level == 0) begin
      armed = 1;
    end
    m_level_d = m_level;
    for (int i = 0; i < 3; i++) begin
      if (seen[i] != m_level[i]) begin
        run[i]++;
        if (run[i] == DB) begin m_level[i] = ~m_level[i]; run[i] = 0; end
      end else begin
        run[i] = 0;
      end
    end
  endtask

  initial model_reset();

  always @(posedge clk) begin
    if (!rst) model_reset();
    else model_step(btn_raw);
    #1;
    check("btn_out", 32'(btn_out), 32'(e_out));
    check("btn_level", 32'(btn_level), 32'(m_level));
    check("conflict", 32'(conflict), 32'(e_conf));
    check("press_cnt", 32'(press_cnt), 32'(e_cnt));
    check("onehot", 32'($countones(btn_out) <= 1), 32'd1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    tick(3);
    check("reset_out", 32'(btn_out), 32'd0);
    check("reset_cnt", 32'(press_cnt), 32'd0);

    // Clean single press: level at edge 6, pulse at edge 7 only.
    rst = 1'b1; btn_raw = 3'b001;
    tick(6);
    check("press_level6", 32'(btn_level), 32'b001);
    check("press_nopulse6", 32'(btn_out), 32'd0);
    tick(1);
    check("press_pulse7", 32'(btn_out), 32'b001);
    check("press_cnt7", 32'(press_cnt), 32'd1);
    tick(1);
    check("press_pulse_end", 32'(btn_out), 32'd0);
    btn_raw = 3'b000; tick(10);

    // Glitch shorter than the debounce window.
    btn_raw = 3'b010; tick(3); btn_raw = 3'b000; tick(10);
    check("glitch_level", 32'(btn_level), 32'd0);
    check("glitch_cnt", 32'(press_cnt), 32'd1);

    // Simultaneous press is a conflict, then a clean press works.
    btn_raw = 3'b101; tick(7);
    check("conf_pulse", 32'(conflict), 32'd1);
    check("conf_out", 32'(btn_out), 32'd0);
    tick(1);
    check("conf_end", 32'(conflict), 32'd0);
    check("conf_cnt", 32'(press_cnt), 32'd1);
    btn_raw = 3'b000; tick(8);
    btn_raw = 3'b010; tick(7);
    check("after_conf_out", 32'(btn_out), 32'b010);
    check("after_conf_cnt", 32'(press_cnt), 32'd2);

    // Second button added while first held is ignored.
    btn_raw = 3'b000; tick(8);
    btn_raw = 3'b001; tick(10);
    btn_raw = 3'b101; tick(10);
    check("held_cnt", 32'(press_cnt), 32'd3);
    btn_raw = 3'b000; tick(8);
    btn_raw = 3'b100; tick(7);
    check("held_next_out", 32'(btn_out), 32'b100);
    check("held_next_cnt", 32'(press_cnt), 32'd4);

    // Reset mid-debounce with a button held.
    btn_raw = 3'b000; tick(8);
    btn_raw = 3'b010; tick(3);
    rst = 1'b0; tick(2);
    check("rst_mid_cnt", 32'(press_cnt), 32'd0);
    rst = 1'b1;
    tick(6);
    check("rst_nopulse6", 32'(btn_out), 32'd0);
    tick(1);
    check("rst_pulse7", 32'(btn_out), 32'b010);
    check("rst_cnt7", 32'(press_cnt), 32'd1);

    // 256 clean presses wrap the counter back to zero.
    btn_raw = 3'b000; tick(8);
    rst = 1'b0; tick(1); rst = 1'b1;
    for (int k = 0; k < 256; k++) begin
      btn_raw = 3'b001; tick(8);
      btn_raw = 3'b000; tick(8);
    end
    check("wrap_cnt", 32'(press_cnt), 32'd0);

    // Random patterns with occasional resets, checked by the model every edge.
    for (int k = 0; k < 400; k++) begin
      btn_raw = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) btn_raw = 3'b000;
      tick($urandom_range(1, 9));
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b0; tick($urandom_range(1, 3)); rst = 1'b1;
      end
    end
    btn_raw = 3'b000; tick(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
